// File: rtl/reg_writeback_if.sv
// Writeback bus bundle: ALU and long-path result inputs, scoreboard reservation,
// stall/error status and the registered register-file write port.
interface reg_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WB_alu_valid;
    logic [ADDR_W-1:0] WB_alu_addr;
    logic [DATA_W-1:0] WB_alu_data;
    logic              WB_lng_valid;
    logic              WB_lng_ready;
    logic [ADDR_W-1:0] WB_lng_addr;
    logic [DATA_W-1:0] WB_lng_data;
    logic              WB_rsv_valid;
    logic [ADDR_W-1:0] WB_rsv_addr;
    logic [31:0]       WB_pending;
    logic              WB_alu_stall;
    logic              WB_err;
    logic              WB_reg_write;
    logic [ADDR_W-1:0] WB_reg_addr;
    logic [DATA_W-1:0] WB_reg_data;

    modport master (
        output WB_alu_valid, WB_alu_addr, WB_alu_data,
        output WB_lng_valid, WB_lng_addr, WB_lng_data,
        output WB_rsv_valid, WB_rsv_addr,
        input  WB_lng_ready, WB_pending, WB_alu_stall, WB_err,
        input  WB_reg_write, WB_reg_addr, WB_reg_data
    );

    modport slave (
        input  WB_alu_valid, WB_alu_addr, WB_alu_data,
        input  WB_lng_valid, WB_lng_addr, WB_lng_data,
        input  WB_rsv_valid, WB_rsv_addr,
        output WB_lng_ready, WB_pending, WB_alu_stall, WB_err,
        output WB_reg_write, WB_reg_addr, WB_reg_data
    );
endinterface

// File: rtl/reg_writeback.sv
// Single register-file write owner: ALU results win unless stalled, long-path results queue in a FIFO.
// Latency 1 cycle to the write port; long path backpressured by FIFO full, ALU throttled via registered stall.
module reg_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          WB_clk,
    input  logic          WB_rst_n,
    reg_writeback_if.slave wb
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        starve_q, starve_d;
    logic              stall_q, stall_d, err_q, err_d;
    logic [31:0]       pending_q, pending_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              fifo_empty, fifo_full, push, pop, alu_win;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [31:0]       set_mask, clr_mask;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        push       = wb.WB_lng_valid && !fifo_full;
        // A stalled ALU only loses when there is actually a queued entry to drain.
        alu_win    = wb.WB_alu_valid && (!stall_q || fifo_empty);
        pop        = !alu_win && !fifo_empty;
        head_addr  = fifo_addr_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wr_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        if (alu_win) begin
            wr_d    = (wb.WB_alu_addr != '0);
            waddr_d = wb.WB_alu_addr;
            wdata_d = wb.WB_alu_data;
        end else if (pop) begin
            wr_d    = (head_addr != '0);
            waddr_d = head_addr;
            wdata_d = head_data;
        end

        starve_d = '0;
        if (alu_win && !fifo_empty)
            starve_d = (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;

        stall_d = stall_q;
        if (starve_d == 2'd3)
            stall_d = 1'b1;
        else if (pop)
            stall_d = 1'b0;

        err_d = err_q || (wb.WB_alu_valid && stall_q && !fifo_empty);

        // Reservation is applied after the clear so a same-cycle re-reserve survives.
        set_mask  = wb.WB_rsv_valid ? (32'd1 << wb.WB_rsv_addr) : 32'd0;
        clr_mask  = pop ? (32'd1 << head_addr) : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge WB_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wb.WB_lng_addr;
            fifo_data_q[wr_ptr_q] <= wb.WB_lng_data;
        end
    end

    always_ff @(posedge WB_clk or negedge WB_rst_n) begin
        if (!WB_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= '0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            wr_q      <= wr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign wb.WB_lng_ready = !fifo_full;
    assign wb.WB_pending   = pending_q;
    assign wb.WB_alu_stall = stall_q;
    assign wb.WB_err       = err_q;
    assign wb.WB_reg_write = wr_q;
    assign wb.WB_reg_addr  = waddr_q;
    assign wb.WB_reg_data  = wdata_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: ALU path, $0 suppression, scoreboard, backpressure/stall, error, reset.
module tb_reg_writeback;
    logic WB_clk = 1'b0;
    logic WB_rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 WB_clk = ~WB_clk;

    reg_writeback_if #(.DATA_W(32), .ADDR_W(5)) wbi ();

    reg_writeback #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
        .WB_clk  (WB_clk),
        .WB_rst_n(WB_rst_n),
        .wb      (wbi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(wbi.WB_reg_write), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(wbi.WB_reg_addr), 32'(a));
            chk({tag, ".data"}, wbi.WB_reg_data, d);
        end
    endtask

    task automatic cyc();
        @(posedge WB_clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        wbi.WB_alu_valid = v;
        wbi.WB_alu_addr  = a;
        wbi.WB_alu_data  = d;
    endtask

    task automatic lng(input logic v, input logic [4:0] a, input logic [31:0] d);
        wbi.WB_lng_valid = v;
        wbi.WB_lng_addr  = a;
        wbi.WB_lng_data  = d;
    endtask

    task automatic rsv(input logic v, input logic [4:0] a);
        wbi.WB_rsv_valid = v;
        wbi.WB_rsv_addr  = a;
    endtask

    initial begin
        alu(1'b0, 5'd0, 32'h0);
        lng(1'b0, 5'd0, 32'h0);
        rsv(1'b0, 5'd0);

        // Reset state
        #3;
        chk_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.addr", 32'(wbi.WB_reg_addr), 32'h0);
        chk("rst.data", wbi.WB_reg_data, 32'h0);
        chk("rst.pending", wbi.WB_pending, 32'h0);
        chk("rst.stall", 32'(wbi.WB_alu_stall), 32'h0);
        chk("rst.err", 32'(wbi.WB_err), 32'h0);
        chk("rst.ready", 32'(wbi.WB_lng_ready), 32'h1);
        #9 WB_rst_n = 1'b1;
        cyc();

        // ALU only
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        cyc();
        chk_wr("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
        alu(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("alu1.after", 1'b0, 5'd0, 32'h0);

        // $0 suppression on both paths
        alu(1'b1, 5'd0, 32'h11);
        cyc();
        chk_wr("zero.alu", 1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        lng(1'b1, 5'd0, 32'h22);
        cyc();
        chk_wr("zero.push", 1'b0, 5'd0, 32'h0);
        lng(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("zero.pop", 1'b0, 5'd0, 32'h0);
        chk("zero.ready", 32'(wbi.WB_lng_ready), 32'h1);
        chk("zero.pending", wbi.WB_pending, 32'h0);
        cyc();
        chk_wr("zero.drained", 1'b0, 5'd0, 32'h0);

        // Scoreboard with long path
        rsv(1'b1, 5'd9);
        cyc();
        rsv(1'b0, 5'd0);
        chk("sb.rsv9", wbi.WB_pending, 32'h0000_0200);
        lng(1'b1, 5'd9, 32'h1234);
        cyc();
        chk_wr("sb.push9", 1'b0, 5'd0, 32'h0);
        chk("sb.pend.held", wbi.WB_pending, 32'h0000_0200);
        lng(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("sb.wr9", 1'b1, 5'd9, 32'h1234);
        chk("sb.pend.clr", wbi.WB_pending, 32'h0);
        rsv(1'b1, 5'd9);
        lng(1'b1, 5'd9, 32'h5678);
        cyc();
        chk("sb.rsv.again", wbi.WB_pending, 32'h0000_0200);
        lng(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("sb.wr9b", 1'b1, 5'd9, 32'h5678);
        chk("sb.setwins", wbi.WB_pending, 32'h0000_0200);
        rsv(1'b0, 5'd0);
        cyc();
        chk("sb.stays", wbi.WB_pending, 32'h0000_0200);

        // Full / backpressure / starvation stall
        alu(1'b1, 5'd3, 32'hA0);
        lng(1'b1, 5'd7, 32'h77);
        cyc();
        chk_wr("full.e1", 1'b1, 5'd3, 32'hA0);
        chk("full.ready1", 32'(wbi.WB_lng_ready), 32'h1);
        lng(1'b1, 5'd8, 32'h88);
        cyc();
        lng(1'b0, 5'd0, 32'h0);
        chk("full.ready0", 32'(wbi.WB_lng_ready), 32'h0);
        chk("full.stall.e2", 32'(wbi.WB_alu_stall), 32'h0);
        cyc();
        chk("full.stall.e3", 32'(wbi.WB_alu_stall), 32'h0);
        cyc();
        chk("full.stall.e4", 32'(wbi.WB_alu_stall), 32'h1);
        chk_wr("full.e4", 1'b1, 5'd3, 32'hA0);
        alu(1'b0, 5'd0, 32'h0);
        chk("full.ready.popcyc", 32'(wbi.WB_lng_ready), 32'h0);
        cyc();
        chk_wr("full.head", 1'b1, 5'd7, 32'h77);
        chk("full.stall.clr", 32'(wbi.WB_alu_stall), 32'h0);
        chk("full.ready.back", 32'(wbi.WB_lng_ready), 32'h1);
        chk("full.err", 32'(wbi.WB_err), 32'h0);
        cyc();
        chk_wr("full.second", 1'b1, 5'd8, 32'h88);
        cyc();
        chk_wr("full.idle", 1'b0, 5'd0, 32'h0);

        // Stall violation
        alu(1'b1, 5'd4, 32'hA4);
        lng(1'b1, 5'd10, 32'h1010);
        cyc();
        lng(1'b1, 5'd11, 32'h1111);
        cyc();
        lng(1'b0, 5'd0, 32'h0);
        cyc();
        cyc();
        chk("viol.stall", 32'(wbi.WB_alu_stall), 32'h1);
        alu(1'b1, 5'd4, 32'hBAD);
        cyc();
        alu(1'b0, 5'd0, 32'h0);
        chk_wr("viol.head", 1'b1, 5'd10, 32'h1010);
        chk("viol.err", 32'(wbi.WB_err), 32'h1);
        cyc();
        chk_wr("viol.second", 1'b1, 5'd11, 32'h1111);
        chk("viol.err.sticky", 32'(wbi.WB_err), 32'h1);
        cyc();
        chk_wr("viol.idle", 1'b0, 5'd0, 32'h0);
        chk("viol.err.sticky2", 32'(wbi.WB_err), 32'h1);

        // Async reset with two queued entries
        alu(1'b1, 5'd1, 32'h0101);
        lng(1'b1, 5'd12, 32'hC);
        rsv(1'b1, 5'd12);
        cyc();
        lng(1'b1, 5'd13, 32'hD);
        rsv(1'b1, 5'd13);
        cyc();
        chk("ar.pending", wbi.WB_pending, 32'h0000_3200);
        chk("ar.ready", 32'(wbi.WB_lng_ready), 32'h0);
        chk_wr("ar.alu", 1'b1, 5'd1, 32'h0101);
        WB_rst_n = 1'b0;
        alu(1'b0, 5'd0, 32'h0);
        lng(1'b0, 5'd0, 32'h0);
        rsv(1'b0, 5'd0);
        #1;
        chk_wr("ar.we", 1'b0, 5'd0, 32'h0);
        chk("ar.addr0", 32'(wbi.WB_reg_addr), 32'h0);
        chk("ar.data0", wbi.WB_reg_data, 32'h0);
        chk("ar.pend0", wbi.WB_pending, 32'h0);
        chk("ar.ready1", 32'(wbi.WB_lng_ready), 32'h1);
        chk("ar.err0", 32'(wbi.WB_err), 32'h0);
        chk("ar.stall0", 32'(wbi.WB_alu_stall), 32'h0);
        #2 WB_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_wr("ar.noqueued", 1'b0, 5'd0, 32'h0);
            chk("ar.pend.after", wbi.WB_pending, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
